score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Game-side producer of the per-player score / game_over interface consumed by the winner
//  selection logic. Runs the round timer and accumulates each player's score from judged hits.
//  Applies a combo multiplier, saturates scores at 9999 and asserts game_over at round end.
//  Sits between the two hit-judgement blocks and the winner selector / VGA score display.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clock cycles per game second (>=2)
//  GAME_SECONDS   60          round length in seconds (1..99)
//  PTS_GOOD       4           base points for grade 01
//  PTS_GREAT      7           base points for grade 10
//  PTS_PERFECT    10          base points for grade 11
//  COMBO_STEP     10          consecutive non-miss hits per multiplier step
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high global reset
//  start         in   1   one-cycle pulse: begin a new round (honoured in IDLE and OVER)
//  abort         in   1   end the current round immediately (honoured in PLAY only)
//  hit_valid_a   in   1   player A judgement strobe, one cycle per judged arrow
//  hit_grade_a   in   2   00 miss, 01 good, 10 great, 11 perfect
//  hit_valid_b   in   1   player B judgement strobe
//  hit_grade_b   in   2   same encoding as hit_grade_a
//  score_a       out  14  player A score, 0..9999
//  score_b       out  14  player B score, 0..9999
//  combo_a       out  8   player A current combo count, saturates at 255
//  combo_b       out  8   player B current combo count
//  seconds_left  out  7   remaining whole seconds in the round
//  playing       out  1   high while in PLAY
//  game_over     out  1   high while in OVER
// BEHAVIOUR
//  - Reset (async): state=IDLE; all scores/combos=0; seconds_left=0; playing=0; game_over=0; tick cnt=0.
//  - FSM: IDLE -start-> PLAY; PLAY -timer expiry or abort-> OVER; OVER -start-> PLAY.
//    start in PLAY is ignored. abort in IDLE/OVER is ignored.
//  - Entering PLAY (the edge that samples start): scores=0, combos=0, tick cnt=0,
//    seconds_left=GAME_SECONDS. playing=1 and game_over=0 in the next cycle.
//  - Timer: tick cnt counts 0..TICKS_PER_SEC-1 in PLAY. On wrap, seconds_left decrements.
//    When the decrement reaches 0, state goes to OVER on that same edge.
//    PLAY lasts exactly GAME_SECONDS*TICKS_PER_SEC cycles.
//  - Hits are processed only in PLAY. Players A and B are independent and may strobe in the same cycle.
//    Hit sampled at edge N is reflected in score/combo after edge N (1-cycle latency).
//    Hits arriving in the expiry/abort cycle are still counted. Hits in IDLE/OVER are dropped.
//  - Per hit: mult = 1 + min(3, combo/COMBO_STEP), using combo before the update.
//    grade 00: combo=0, score unchanged.
//    grade 01/10/11: score = min(9999, score + pts*mult); combo = min(255, combo+1).
//    The 14-bit sum max is 9999+40, so no overflow before the clamp.
//  - OVER: game_over=1, playing=0. Scores, combos and seconds_left are frozen for the whole time
//    game_over is high, so a downstream latch sees stable values on the first game_over cycle.
//  - start in OVER: game_over falls and scores clear on the same edge. The downstream latch re-arms.
//  - abort and timer expiry in the same cycle: single transition to OVER, no double effect.
//  - start and abort in the same cycle: start is honoured only if state is IDLE/OVER, abort only if PLAY.
//    The two are therefore never both active.
//  - Reset mid-round: immediate return to IDLE with all outputs at reset values. No game_over pulse.
// TESTING  (TICKS_PER_SEC=4, GAME_SECONDS=3 unless stated)
//  1. Reset, pulse start -> playing=1, seconds_left=3. game_over rises exactly 12 cycles after PLAY entry.
//     seconds_left goes 3,2,1,0.
//  2. 11 consecutive perfect hits on A -> score_a=100 after 10 hits, 120 after the 11th.
//     combo_a=11, score_b=0.
//  3. A: great, great, miss, good -> score_a=7, 14, 14, 18; combo_a=1, 2, 0, 1.
//     Simultaneous B perfect strobes score B independently.
//  4. Preload near cap (GAME_SECONDS=99, 1000 perfects at mult 4 = 40 pts each) -> score_a clamps at 9999
//     and stays 9999 on further hits. combo_a clamps at 255.
//  5. Hit in the expiry cycle is counted. Hits in OVER leave scores unchanged.
//     abort in PLAY -> game_over next cycle. start in OVER -> game_over=0, scores=0 next cycle.
//  6. Assert reset mid-round with nonzero scores -> all outputs 0 asynchronously.
//     After release, start begins a clean round.

Source files
------------

// File: rtl/score_keeper.sv
// Round timer and per-player score/combo accumulator feeding the winner selector.
// Scores, combos and seconds_left hold still for as long as game_over is high.
module score_keeper #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int PTS_GOOD      = 4,
  parameter int PTS_GREAT     = 7,
  parameter int PTS_PERFECT   = 10,
  parameter int COMBO_STEP    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        hit_valid_a,
  input  logic [1:0]  hit_grade_a,
  input  logic        hit_valid_b,
  input  logic [1:0]  hit_grade_b,
  output logic [13:0] score_a,
  output logic [13:0] score_b,
  output logic [7:0]  combo_a,
  output logic [7:0]  combo_b,
  output logic [6:0]  seconds_left,
  output logic        playing,
  output logic        game_over
);

  localparam int            TW         = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [13:0]   SCORE_MAX  = 14'd9999;
  localparam logic [6:0]    SECS_START = 7'(GAME_SECONDS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_enter;
  logic [TW-1:0] r_tick;
  logic [6:0]    r_secs;
  logic [13:0]   r_score_a, r_score_b;
  logic [7:0]    r_combo_a, r_combo_b;
  logic [13:0]   w_score_a_nxt, w_score_b_nxt;
  logic [7:0]    w_combo_a_nxt, w_combo_b_nxt;
  logic          w_wrap;
  logic          w_expire;

  // Points for one hit: base points times 1 + min(3, combo / COMBO_STEP).
  function automatic logic [5:0] hit_points(input logic [1:0] grade, input logic [7:0] combo);
    int unsigned steps;
    int unsigned base;
    steps = int'(combo) / COMBO_STEP;
    if (steps > 3) steps = 3;
    case (grade)
      2'b01:   base = PTS_GOOD;
      2'b10:   base = PTS_GREAT;
      2'b11:   base = PTS_PERFECT;
      default: base = 0;
    endcase
    return 6'(base * (steps + 1));
  endfunction

  function automatic logic [13:0] sat_score(input logic [13:0] score, input logic [5:0] add);
    logic [14:0] sum;
    sum = {1'b0, score} + {9'd0, add};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[13:0];
  endfunction

  function automatic logic [7:0] sat_combo(input logic [7:0] combo);
    return (combo == 8'hFF) ? combo : combo + 8'd1;
  endfunction

  assign w_wrap   = (r_tick == TICK_LAST);
  assign w_expire = w_wrap && (r_secs == 7'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_PLAY;
        w_enter     = 1'b1;
      end
      S_PLAY: if (w_expire || abort) w_state_nxt = S_OVER;
      S_OVER: if (start) begin
        w_state_nxt = S_PLAY;
        w_enter     = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_score_a_nxt = r_score_a;
    w_combo_a_nxt = r_combo_a;
    w_score_b_nxt = r_score_b;
    w_combo_b_nxt = r_combo_b;
    if (hit_valid_a) begin
      if (hit_grade_a == 2'b00) w_combo_a_nxt = 8'd0;
      else begin
        w_score_a_nxt = sat_score(r_score_a, hit_points(hit_grade_a, r_combo_a));
        w_combo_a_nxt = sat_combo(r_combo_a);
      end
    end
    if (hit_valid_b) begin
      if (hit_grade_b == 2'b00) w_combo_b_nxt = 8'd0;
      else begin
        w_score_b_nxt = sat_score(r_score_b, hit_points(hit_grade_b, r_combo_b));
        w_combo_b_nxt = sat_combo(r_combo_b);
      end
    end
  end

  // Hits and the timer only advance in PLAY; the expiry/abort cycle still counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick    <= '0;
      r_secs    <= 7'd0;
      r_score_a <= 14'd0;
      r_score_b <= 14'd0;
      r_combo_a <= 8'd0;
      r_combo_b <= 8'd0;
    end else if (w_enter) begin
      r_tick    <= '0;
      r_secs    <= SECS_START;
      r_score_a <= 14'd0;
      r_score_b <= 14'd0;
      r_combo_a <= 8'd0;
      r_combo_b <= 8'd0;
    end else if (r_state == S_PLAY) begin
      r_tick    <= w_wrap ? '0 : r_tick + 1'b1;
      if (w_wrap) r_secs <= r_secs - 7'd1;
      r_score_a <= w_score_a_nxt;
      r_score_b <= w_score_b_nxt;
      r_combo_a <= w_combo_a_nxt;
      r_combo_b <= w_combo_b_nxt;
    end
  end

  assign score_a      = r_score_a;
  assign score_b      = r_score_b;
  assign combo_a      = r_combo_a;
  assign combo_b      = r_combo_b;
  assign seconds_left = r_secs;
  assign playing      = (r_state == S_PLAY);
  assign game_over    = (r_state == S_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (short 3s round, long 99s round) share one stimulus
// stream and are compared every cycle against a cycle-count based reference model.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       st, ab;
  logic       va, vb;
  logic [1:0] ga, gb;

  logic [13:0] o_sa   [2];
  logic [13:0] o_sb   [2];
  logic [7:0]  o_ca   [2];
  logic [7:0]  o_cb   [2];
  logic [6:0]  o_sec  [2];
  logic        o_play [2];
  logic        o_over [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0 idle, 1 play, 2 over; time measured as cycles spent in PLAY.
  int m_tps [2] = '{4, 16};
  int m_gs  [2] = '{3, 99};
  int m_st  [2];
  int m_cyc [2];
  int m_sec [2];
  int m_sa  [2];
  int m_sb  [2];
  int m_ca  [2];
  int m_cb  [2];

  always #5 clk = ~clk;

  score_keeper #(.TICKS_PER_SEC(4), .GAME_SECONDS(3)) u_dut0 (
    .clock(clk), .reset(rst), .start(st), .abort(ab),
    .hit_valid_a(va), .hit_grade_a(ga), .hit_valid_b(vb), .hit_grade_b(gb),
    .score_a(o_sa[0]), .score_b(o_sb[0]), .combo_a(o_ca[0]), .combo_b(o_cb[0]),
    .seconds_left(o_sec[0]), .playing(o_play[0]), .game_over(o_over[0])
  );

  score_keeper #(.TICKS_PER_SEC(16), .GAME_SECONDS(99)) u_dut1 (
    .clock(clk), .reset(rst), .start(st), .abort(ab),
    .hit_valid_a(va), .hit_grade_a(ga), .hit_valid_b(vb), .hit_grade_b(gb),
    .score_a(o_sa[1]), .score_b(o_sb[1]), .combo_a(o_ca[1]), .combo_b(o_cb[1]),
    .seconds_left(o_sec[1]), .playing(o_play[1]), .game_over(o_over[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pts(input logic [1:0] g);
    case (g)
      2'b01:   return 4;
      2'b10:   return 7;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  task automatic model_hit(input logic v, input logic [1:0] g, inout int sc, inout int cb);
    int mult;
    if (!v) return;
    mult = 1 + ((cb / 10 > 3) ? 3 : cb / 10);
    if (g == 2'b00) cb = 0;
    else begin
      sc = sc + pts(g) * mult;
      if (sc > 9999) sc = 9999;
      if (cb < 255) cb = cb + 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cyc[k] = 0; m_sec[k] = 0;
      m_sa[k] = 0; m_sb[k] = 0; m_ca[k] = 0; m_cb[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    if (m_st[k] == 1) begin
      model_hit(va, ga, m_sa[k], m_ca[k]);
      model_hit(vb, gb, m_sb[k], m_cb[k]);
      m_cyc[k] = m_cyc[k] + 1;
      m_sec[k] = m_gs[k] - m_cyc[k] / m_tps[k];
      if (m_cyc[k] == m_gs[k] * m_tps[k] || ab) m_st[k] = 2;
    end else if (st) begin
      m_st[k] = 1; m_cyc[k] = 0; m_sec[k] = m_gs[k];
      m_sa[k] = 0; m_sb[k] = 0; m_ca[k] = 0; m_cb[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.score_a", k), 32'(o_sa[k]), 32'(m_sa[k]));
      check($sformatf("u%0d.score_b", k), 32'(o_sb[k]), 32'(m_sb[k]));
      check($sformatf("u%0d.combo_a", k), 32'(o_ca[k]), 32'(m_ca[k]));
      check($sformatf("u%0d.combo_b", k), 32'(o_cb[k]), 32'(m_cb[k]));
      check($sformatf("u%0d.seconds_left", k), 32'(o_sec[k]), 32'(m_sec[k]));
      check($sformatf("u%0d.playing", k), 32'(o_play[k]), 32'(m_st[k] == 1));
      check($sformatf("u%0d.game_over", k), 32'(o_over[k]), 32'(m_st[k] == 2));
    end
  endtask

  task automatic tick(input logic s, input logic a, input logic v_a, input logic [1:0] g_a,
                      input logic v_b, input logic [1:0] g_b);
    st = s; ab = a; va = v_a; ga = g_a; vb = v_b; gb = g_b;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
    st = 1'b0; ab = 1'b0; va = 1'b0; vb = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; st = 1'b0; ab = 1'b0; va = 1'b0; vb = 1'b0; ga = 2'b00; gb = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Round timing on the short instance.
    tick(1, 0, 0, 2'b00, 0, 2'b00);
    check("t1_playing", 32'(o_play[0]), 32'd1);
    check("t1_secs_start", 32'(o_sec[0]), 32'd3);
    n = 0;
    while (!o_over[0] && n < 40) begin
      tick(0, 0, 0, 2'b00, 0, 2'b00);
      n++;
    end
    check("t1_over_latency", 32'(n), 32'd12);
    check("t1_secs_end", 32'(o_sec[0]), 32'd0);

    // Abort ends the long round on the next edge.
    tick(0, 1, 0, 2'b00, 0, 2'b00);
    check("abort_over", 32'(o_over[1]), 32'd1);

    // Consecutive perfects with combo multiplier, then a hit on the expiry edge.
    tick(1, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 11; i++) begin
      tick(0, 0, 1, 2'b11, 0, 2'b00);
      if (i == 9) check("t2_score_10", 32'(o_sa[0]), 32'd100);
    end
    check("t2_score_11", 32'(o_sa[0]), 32'd120);
    check("t2_combo_11", 32'(o_ca[0]), 32'd11);
    check("t2_score_b", 32'(o_sb[0]), 32'd0);
    tick(0, 0, 1, 2'b11, 0, 2'b00);
    check("expiry_hit", 32'(o_sa[0]), 32'd140);
    check("expiry_over", 32'(o_over[0]), 32'd1);

    // Long run of perfects: long instance saturates, short one is frozen in OVER.
    repeat (420) tick(0, 0, 1, 2'b11, 0, 2'b00);
    check("cap_score", 32'(o_sa[1]), 32'd9999);
    check("cap_combo", 32'(o_ca[1]), 32'd255);
    check("over_frozen", 32'(o_sa[0]), 32'd140);

    // Restart from OVER, mixed grades on A with B scoring independently.
    tick(1, 0, 0, 2'b00, 0, 2'b00);
    check("restart_over", 32'(o_over[0]), 32'd0);
    check("restart_score", 32'(o_sa[0]), 32'd0);
    tick(0, 0, 1, 2'b10, 1, 2'b11);
    check("t3_s1", 32'(o_sa[0]), 32'd7);
    check("t3_c1", 32'(o_ca[0]), 32'd1);
    tick(0, 0, 1, 2'b10, 1, 2'b11);
    check("t3_s2", 32'(o_sa[0]), 32'd14);
    check("t3_c2", 32'(o_ca[0]), 32'd2);
    tick(0, 0, 1, 2'b00, 1, 2'b11);
    check("t3_s3", 32'(o_sa[0]), 32'd14);
    check("t3_c3", 32'(o_ca[0]), 32'd0);
    tick(0, 0, 1, 2'b01, 1, 2'b11);
    check("t3_s4", 32'(o_sa[0]), 32'd18);
    check("t3_c4", 32'(o_ca[0]), 32'd1);
    check("t3_b", 32'(o_sb[0]), 32'd40);

    // Randomised traffic, including start/abort collisions.
    for (int i = 0; i < 700; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a scoring round.
    tick(0, 1, 0, 2'b00, 0, 2'b00);
    tick(1, 0, 0, 2'b00, 0, 2'b00);
    repeat (3) tick(0, 0, 1, 2'b11, 1, 2'b01);
    check("pre_reset_score", 32'(o_sa[0]), 32'd30);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    tick(1, 0, 0, 2'b00, 0, 2'b00);
    check("post_reset_play", 32'(o_play[0]), 32'd1);
    check("post_reset_secs", 32'(o_sec[0]), 32'd3);
    tick(0, 0, 1, 2'b11, 0, 2'b00);
    check("post_reset_hit", 32'(o_sa[0]), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
